// File: rtl/mips_ctrl_pkg.sv
// Shared types and instruction-field constants for the multicycle MIPS controller.
package mips_ctrl_pkg;

   typedef enum logic [3:0] {
      ALU_AND = 4'b0000,
      ALU_OR  = 4'b0001,
      ALU_ADD = 4'b0010,
      ALU_SUB = 4'b0110,
      ALU_SLT = 4'b0111,
      ALU_NOR = 4'b1100
   } alu_op_t;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd7
   } ctrl_state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADDU = 6'b100001;
   localparam logic [5:0] FN_SUBU = 6'b100011;
   localparam logic [5:0] FN_AND  = 6'b100100;
   localparam logic [5:0] FN_OR   = 6'b100101;
   localparam logic [5:0] FN_NOR  = 6'b100111;
   localparam logic [5:0] FN_SLT  = 6'b101010;

   function automatic logic funct_supported(input logic [5:0] funct);
      case (funct)
         FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_NOR, FN_SLT: return 1'b1;
         default:                                          return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mips_alu_decoder.sv
// Combinational ALU operation decode; ADD everywhere except the EXEC phase.
module mips_alu_decoder
   import mips_ctrl_pkg::*;
(
   input  logic       exec_phase,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output alu_op_t    alu_op
);

   always_comb begin
      alu_op = ALU_ADD;
      if (exec_phase) begin
         case (opcode)
            OP_RTYPE: begin
               case (funct)
                  FN_ADDU: alu_op = ALU_ADD;
                  FN_SUBU: alu_op = ALU_SUB;
                  FN_AND:  alu_op = ALU_AND;
                  FN_OR:   alu_op = ALU_OR;
                  FN_NOR:  alu_op = ALU_NOR;
                  FN_SLT:  alu_op = ALU_SLT;
                  default: alu_op = ALU_ADD;
               endcase
            end
            OP_BEQ:  alu_op = ALU_SUB;
            default: alu_op = ALU_ADD;
         endcase
      end
   end

endmodule

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB/HALT).
// Optional MIPS_MC_STALL_COUNT_EN adds the stall_cycles waitrequest counter.
module mips_mc_controller
   import mips_ctrl_pkg::*;
#(
   parameter bit RESET_VECTOR_ZERO_HALT = 1'b1
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic [5:0]  opcode,
   input  logic [5:0]  funct,
   input  logic        pc_zero,
   input  logic        alu_zero,
   input  logic        mem_waitrequest,
   output logic [3:0]  alu_op,
   output logic        alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic        iord,
   output logic        mem_read,
   output logic        mem_write,
   output logic        ir_write,
   output logic        pc_write,
   output logic [1:0]  pc_src,
   output logic        reg_write,
   output logic        reg_dst,
   output logic        mem_to_reg,
   output logic        active,
   output logic [2:0]  state_o
`ifdef MIPS_MC_STALL_COUNT_EN
   ,
   output logic [31:0] stall_cycles
`endif
);

   ctrl_state_t state, state_next;
   logic        first_fetch;
   logic        halt_req;
   alu_op_t     alu_op_dec;

   assign halt_req = RESET_VECTOR_ZERO_HALT && first_fetch && pc_zero;

   mips_alu_decoder u_alu_decoder (
      .exec_phase (state == S_EXEC && !reset),
      .opcode     (opcode),
      .funct      (funct),
      .alu_op     (alu_op_dec)
   );

   assign alu_op  = alu_op_dec;
   assign state_o = state;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_FETCH;
         first_fetch <= 1'b1;
      end else begin
         state <= state_next;
         if (state == S_FETCH && !mem_waitrequest)
            first_fetch <= 1'b0;
      end
   end

   // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
   always_comb begin
      state_next = state;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'd0;
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 2'd0;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      active     = reset || (state != S_HALT);

      // While reset is held the decode is suppressed so strobes read as cleared.
      if (!reset) begin
         unique case (state)
            S_FETCH: begin
               if (halt_req) begin
                  state_next = S_HALT;
               end else begin
                  mem_read  = 1'b1;
                  alu_src_b = 2'd1;
                  if (!mem_waitrequest) begin
                     ir_write   = 1'b1;
                     pc_write   = 1'b1;
                     state_next = S_DECODE;
                  end
               end
            end
            S_DECODE: begin
               alu_src_b  = 2'd3;
               state_next = S_EXEC;
            end
            S_EXEC: begin
               state_next = S_FETCH;
               case (opcode)
                  OP_RTYPE: begin
                     if (funct_supported(funct)) begin
                        alu_src_a  = 1'b1;
                        state_next = S_WB;
                     end
                  end
                  OP_LW, OP_SW: begin
                     alu_src_a  = 1'b1;
                     alu_src_b  = 2'd2;
                     state_next = S_MEM;
                  end
                  OP_ADDIU: begin
                     alu_src_a  = 1'b1;
                     alu_src_b  = 2'd2;
                     state_next = S_WB;
                  end
                  OP_BEQ: begin
                     alu_src_a = 1'b1;
                     pc_src    = 2'd1;
                     pc_write  = alu_zero;
                  end
                  OP_J: begin
                     pc_src   = 2'd2;
                     pc_write = 1'b1;
                  end
                  default: ;
               endcase
            end
            S_MEM: begin
               iord       = 1'b1;
               mem_read   = (opcode == OP_LW);
               mem_write  = (opcode == OP_SW);
               state_next = S_FETCH;
               if ((opcode == OP_LW || opcode == OP_SW) && mem_waitrequest)
                  state_next = S_MEM;
               else if (opcode == OP_LW)
                  state_next = S_WB;
            end
            S_WB: begin
               state_next = S_FETCH;
               case (opcode)
                  OP_RTYPE: begin
                     reg_write = 1'b1;
                     reg_dst   = 1'b1;
                  end
                  OP_ADDIU: reg_write = 1'b1;
                  OP_LW: begin
                     reg_write  = 1'b1;
                     mem_to_reg = 1'b1;
                  end
                  default: ;
               endcase
            end
            S_HALT:  state_next = S_HALT;
            default: state_next = S_FETCH;
         endcase
      end
   end

`ifdef MIPS_MC_STALL_COUNT_EN
   logic stall;

   assign stall = !reset && mem_waitrequest &&
                  ((state == S_FETCH && !halt_req) ||
                   (state == S_MEM && (opcode == OP_LW || opcode == OP_SW)));

   always_ff @(posedge clk) begin
      if (reset)
         stall_cycles <= '0;
      else if (stall)
         stall_cycles <= stall_cycles + 32'd1;
   end
`endif

endmodule

// File: tb/tb_mips_mc_controller.sv
// Self-checking bench: per-instruction expected control traces built from the phase rules.
`timescale 1ns/1ps
module tb_mips_mc_controller;

   localparam logic [5:0] T_LW = 6'b100011, T_SW = 6'b101011, T_BEQ = 6'b000100;
   localparam logic [5:0] T_ADDIU = 6'b001001, T_J = 6'b000010, T_R = 6'b000000;

   typedef struct packed {
      logic [2:0] st;
      logic [3:0] aop;
      logic       sa;
      logic [1:0] sb;
      logic       iord;
      logic       mr;
      logic       mw;
      logic       irw;
      logic       pcw;
      logic [1:0] psrc;
      logic       rw;
      logic       rdst;
      logic       m2r;
      logic       act;
   } ctl_t;

   typedef struct packed {
      ctl_t c;
      logic wreq;
   } step_t;

   logic        clk, reset;
   logic [5:0]  opcode, funct;
   logic        pc_zero, alu_zero, mem_waitrequest;
   logic [3:0]  alu_op;
   logic        alu_src_a;
   logic [1:0]  alu_src_b;
   logic        iord, mem_read, mem_write, ir_write, pc_write;
   logic [1:0]  pc_src;
   logic        reg_write, reg_dst, mem_to_reg, active;
   logic [2:0]  state_o;
`ifdef MIPS_MC_STALL_COUNT_EN
   logic [31:0] stall_cycles;
`endif

   int checks = 0;
   int failures = 0;
   int exp_stall = 0;
   step_t trace[$];
   ctl_t obs;

   mips_mc_controller dut (
      .clk             (clk),
      .reset           (reset),
      .opcode          (opcode),
      .funct           (funct),
      .pc_zero         (pc_zero),
      .alu_zero        (alu_zero),
      .mem_waitrequest (mem_waitrequest),
      .alu_op          (alu_op),
      .alu_src_a       (alu_src_a),
      .alu_src_b       (alu_src_b),
      .iord            (iord),
      .mem_read        (mem_read),
      .mem_write       (mem_write),
      .ir_write        (ir_write),
      .pc_write        (pc_write),
      .pc_src          (pc_src),
      .reg_write       (reg_write),
      .reg_dst         (reg_dst),
      .mem_to_reg      (mem_to_reg),
      .active          (active),
      .state_o         (state_o)
`ifdef MIPS_MC_STALL_COUNT_EN
      ,
      .stall_cycles    (stall_cycles)
`endif
   );

   assign obs = {state_o, alu_op, alu_src_a, alu_src_b, iord, mem_read, mem_write,
                 ir_write, pc_write, pc_src, reg_write, reg_dst, mem_to_reg, active};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
      checks++;
      assert (o === e) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, o, e);
      end
   endtask

   task automatic check_stall(input string tag);
`ifdef MIPS_MC_STALL_COUNT_EN
      check({tag, " stall_cycles"}, stall_cycles, 32'(exp_stall));
`endif
   endtask

   function automatic ctl_t idle(input logic [2:0] st);
      ctl_t c;
      c     = '0;
      c.st  = st;
      c.aop = 4'b0010;
      c.act = 1'b1;
      return c;
   endfunction

   // Bit 4 flags a supported R-type funct; bits 3:0 give its ALU code.
   function automatic logic [4:0] r_alu(input logic [5:0] fn);
      case (fn)
         6'b100001: return 5'b1_0010;
         6'b100011: return 5'b1_0110;
         6'b100100: return 5'b1_0000;
         6'b100101: return 5'b1_0001;
         6'b100111: return 5'b1_1100;
         6'b101010: return 5'b1_0111;
         default:   return 5'b0_0000;
      endcase
   endfunction

   task automatic push(input ctl_t c, input logic w);
      step_t s;
      s.c    = c;
      s.wreq = w;
      trace.push_back(s);
   endtask

   // Expected cycle-by-cycle trace of one instruction from fetch to its last phase.
   task automatic build(input logic [5:0] op, input logic [5:0] fn, input int fs,
                        input int ms, input logic zero);
      ctl_t c;
      logic [4:0] r;
      bit is_mem;
      c = idle(3'd0); c.mr = 1'b1; c.sb = 2'd1;
      for (int i = 0; i < fs; i++) push(c, 1'b1);
      c.irw = 1'b1; c.pcw = 1'b1;
      push(c, 1'b0);
      c = idle(3'd1); c.sb = 2'd3;
      push(c, 1'b0);
      c = idle(3'd2);
      r = r_alu(fn);
      is_mem = (op == T_LW) || (op == T_SW);
      if (op == T_R && r[4]) begin
         c.sa = 1'b1; c.aop = r[3:0];
         push(c, 1'b0);
         c = idle(3'd4); c.rw = 1'b1; c.rdst = 1'b1;
         push(c, 1'b0);
      end else if (is_mem || op == T_ADDIU) begin
         c.sa = 1'b1; c.sb = 2'd2;
         push(c, 1'b0);
         if (is_mem) begin
            c = idle(3'd3); c.iord = 1'b1;
            c.mr = (op == T_LW); c.mw = (op == T_SW);
            for (int i = 0; i < ms; i++) push(c, 1'b1);
            push(c, 1'b0);
         end
         if (op != T_SW) begin
            c = idle(3'd4); c.rw = 1'b1; c.m2r = (op == T_LW);
            push(c, 1'b0);
         end
      end else if (op == T_BEQ) begin
         c.sa = 1'b1; c.aop = 4'b0110; c.psrc = 2'd1; c.pcw = zero;
         push(c, 1'b0);
      end else if (op == T_J) begin
         c.psrc = 2'd2; c.pcw = 1'b1;
         push(c, 1'b0);
      end else begin
         push(c, 1'b0);
      end
   endtask

   // Plays up to 'limit' queued cycles; IR fields are garbage until the fetch completes.
   task automatic run_trace(input string tag, input logic [5:0] op, input logic [5:0] fn,
                            input int limit);
      step_t s;
      int n = 0;
      while (trace.size() > 0 && n < limit) begin
         s = trace.pop_front();
         mem_waitrequest = s.wreq;
         if (s.c.st == 3'd0) begin
            opcode = 6'($urandom);
            funct  = 6'($urandom);
         end else begin
            opcode = op;
            funct  = fn;
         end
         if (s.wreq) exp_stall++;
         @(negedge clk);
         check($sformatf("%s step%0d ctl", tag, n), 32'(obs), 32'(s.c));
         @(posedge clk); #1;
         n++;
      end
   endtask

   task automatic do_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                           input int fs, input int ms, input logic zero, input logic pcz);
      alu_zero = zero;
      pc_zero  = pcz;
      build(op, fn, fs, ms, zero);
      run_trace(tag, op, fn, 1000);
      check_stall(tag);
   endtask

   task automatic reset_pulse(input string tag, input int cycles);
      reset = 1'b1;
      mem_waitrequest = 1'b0;
      trace.delete();
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk); #1;
         check($sformatf("%s reset%0d ctl", tag, i), 32'(obs), 32'(idle(3'd0)));
      end
      exp_stall = 0;
      check_stall(tag);
      reset = 1'b0;
   endtask

   initial begin
      logic [5:0] ops[8];
      logic [5:0] fns[6];
      logic [5:0] op, fn;
      ctl_t hc;

      ops = '{T_R, T_R, T_LW, T_SW, T_ADDIU, T_BEQ, T_J, 6'b111111};
      fns = '{6'b100001, 6'b100011, 6'b100100, 6'b100101, 6'b100111, 6'b101010};
      reset = 1'b1; opcode = '0; funct = '0; pc_zero = 1'b0;
      alu_zero = 1'b0; mem_waitrequest = 1'b0;

      reset_pulse("init", 2);
      do_instr("rtype_slt", T_R, 6'b101010, 0, 0, 1'b0, 1'b0);
      do_instr("lw_stall3", T_LW, 6'h15, 0, 3, 1'b0, 1'b0);
      do_instr("beq_taken", T_BEQ, 6'h00, 0, 0, 1'b1, 1'b0);
      do_instr("beq_not", T_BEQ, 6'h00, 0, 0, 1'b0, 1'b0);
      do_instr("sw", T_SW, 6'h2a, 0, 0, 1'b1, 1'b0);
      do_instr("addiu_fstall", T_ADDIU, 6'h01, 2, 0, 1'b0, 1'b1);
      do_instr("jump", T_J, 6'h3f, 1, 0, 1'b0, 1'b0);
      do_instr("rtype_badfn", T_R, 6'b000000, 0, 0, 1'b1, 1'b0);
      do_instr("bad_opcode", 6'b111111, 6'b101010, 0, 0, 1'b0, 1'b0);

      for (int i = 0; i < 40; i++) begin
         op = ops[$urandom_range(7)];
         if (op == 6'b111111) op = 6'($urandom);
         fn = ($urandom_range(4) == 0) ? 6'($urandom) : fns[$urandom_range(5)];
         do_instr($sformatf("rnd%0d", i), op, fn, $urandom_range(3), $urandom_range(3),
                  1'($urandom), 1'($urandom));
      end

      // pc_zero on the first fetch after reset parks the FSM in HALT.
      pc_zero = 1'b1;
      reset_pulse("halt", 2);
      mem_waitrequest = 1'($urandom);
      @(negedge clk);
      check("halt fetch ctl", 32'(obs), 32'(idle(3'd0)));
      @(posedge clk); #1;
      hc = idle(3'd7); hc.act = 1'b0;
      for (int i = 0; i < 10; i++) begin
         mem_waitrequest = 1'($urandom);
         pc_zero  = 1'($urandom);
         opcode   = 6'($urandom);
         funct    = 6'($urandom);
         alu_zero = 1'($urandom);
         @(negedge clk);
         check($sformatf("halt cyc%0d ctl", i), 32'(obs), 32'(hc));
         @(posedge clk); #1;
      end
      check_stall("halt");

      pc_zero = 1'b0;
      reset_pulse("recover", 1);
      do_instr("post_halt", T_R, 6'b100011, 0, 0, 1'b0, 1'b0);
      build(T_R, 6'b100001, 5, 0, 1'b0);
      run_trace("fetch_stall", T_R, 6'b100001, 2);
      reset_pulse("mid_fetch", 1);
      do_instr("after_fetch_rst", T_LW, 6'h00, 1, 2, 1'b0, 1'b0);
      build(T_SW, 6'h00, 0, 4, 1'b0);
      run_trace("mem_stall", T_SW, 6'h00, 5);
      reset_pulse("mid_mem", 1);
      do_instr("after_mem_rst", T_SW, 6'h00, 0, 1, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mips_mc_controller.md
Name: mips_mc_controller

Overview:
Multicycle control FSM for the MIPS CPU datapath. Sequences the shared ALU, memory port, IR, PC and register file through FETCH/DECODE/EXEC/MEM/WB phases. Drives the 4-bit ALU operation code and all mux/enable strobes. Stalls on the Avalon-style memory waitrequest.

Parameters:
RESET_VECTOR_ZERO_HALT, 1, when 1 the FSM enters HALT on the first fetch attempted with pc_zero=1 after reset release.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
opcode  in  6  IR[31:26]
funct  in  6  IR[5:0]
pc_zero  in  1  PC register currently equals 0
alu_zero  in  1  zero flag from ALU
mem_waitrequest  in  1  memory not ready; hold request
alu_op  out  4  ALU operation code
alu_src_a  out  1  0=PC, 1=reg A
alu_src_b  out  2  0=reg B, 1=const 4, 2=sign-ext imm, 3=sign-ext imm<<2
iord  out  1  memory address select, 0=PC, 1=ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
ir_write  out  1  latch instruction register
pc_write  out  1  PC load enable
pc_src  out  2  0=ALU result, 1=ALUOut, 2=jump target
reg_write  out  1  register file write enable
reg_dst  out  1  0=rt, 1=rd
mem_to_reg  out  1  0=ALUOut, 1=MDR
active  out  1  high while not halted
state_o  out  3  current state encoding, debug

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on port reset.
- Reset: state=FETCH. All strobes (mem_read, mem_write, ir_write, pc_write, reg_write) are 0. alu_op=ADD, selects=0, active=1.
- ALU codes: AND=0000, OR=0001, ADD=0010, SUB=0110, SLT=0111, NOR=1100.
- All outputs are combinational decodes of the registered state plus opcode/funct. No output registers.
- State encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7.

FETCH:
- If pc_zero and first fetch after reset (RESET_VECTOR_ZERO_HALT=1), go to HALT.
- Otherwise mem_read=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=ADD.
- While mem_waitrequest=1: hold, with no ir_write or pc_write.
- When mem_waitrequest=0: ir_write=1, pc_write=1, pc_src=0, go to DECODE.

DECODE:
- alu_src_a=0, alu_src_b=3, alu_op=ADD (branch target precompute).
- Always go to EXEC.

EXEC, by opcode:
- R-type (000000): alu_src_a=1, alu_src_b=0. Funct mapping: 100001→ADD, 100011→SUB, 100100→AND, 100101→OR, 100111→NOR, 101010→SLT. Go to WB.
- LW (100011) / SW (101011): alu_src_a=1, alu_src_b=2, alu_op=ADD. Go to MEM.
- ADDIU (001001): same ALU setup as LW/SW. Go to WB.
- BEQ (000100): alu_src_a=1, alu_src_b=0, alu_op=SUB, pc_src=1, pc_write=alu_zero. Go to FETCH.
- J (000010): pc_src=2, pc_write=1. Go to FETCH.
- Unsupported opcode or funct: no strobes, treat as NOP, go to FETCH.

MEM:
- iord=1. LW asserts mem_read; SW asserts mem_write.
- Held stable while mem_waitrequest=1.
- On release: SW goes to FETCH, LW goes to WB.

WB:
- reg_write=1.
- R-type: reg_dst=1, mem_to_reg=0.
- ADDIU: reg_dst=0, mem_to_reg=0.
- LW: reg_dst=0, mem_to_reg=1.
- Go to FETCH.

HALT:
- Absorbing state; active=0, all strobes 0.
- Exit only via reset.

Boundaries:
- mem_read and mem_write are never asserted together.
- Reset mid-operation, including mid-waitrequest stall, returns to FETCH next cycle with strobes cleared.
- Outputs are stable for the whole waitrequest stall.

Optional Feature:
- Macro: MIPS_MC_STALL_COUNT_EN.
- Defined: adds output stall_cycles[31:0]. It increments each cycle the FSM holds in FETCH or MEM due to mem_waitrequest, wraps at 2^32, and clears on reset.
- Undefined: port and counter absent. FSM behaviour identical either way.

Decomposition:
- Package mips_ctrl_pkg holds:
  - alu_op_t enum with the six codes above
  - ctrl_state_t enum
  - opcode localparams: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDIU, OP_J
  - funct localparams
- One sub-module: mips_alu_decoder. It is combinational and maps {exec_phase, opcode, funct} → alu_op. The FSM instantiates it.

Test Plan:
1. Reset high 2 cycles, release, waitrequest=0 → state sequence FETCH(0), DECODE(1). ir_write=1 and pc_write=1 for exactly one cycle in FETCH.
2. R-type funct=101010 → alu_op=0111 in EXEC. In WB: reg_write=1, reg_dst=1. Back to FETCH; total 4 cycles.
3. LW with waitrequest high 3 cycles in MEM → mem_read held 4 cycles, iord=1, then WB with mem_to_reg=1. 5 cycles plus 3 stall cycles; stall_cycles=3 if MIPS_MC_STALL_COUNT_EN.
4. BEQ with alu_zero=1 → EXEC: alu_op=0110, pc_write=1, pc_src=1. Repeat with alu_zero=0 → pc_write=0.
5. SW → exactly one mem_write cycle with waitrequest=0, no reg_write anywhere in the sequence.
6. pc_zero=1 at first fetch → HALT(7), active=0, strobes 0 for 10 cycles. Then reset mid-stall of a later fetch → FETCH next cycle.
